// File: rtl/jace_ps2_keyboard_pkg.sv
// Shared types and constants for the Jupiter Ace PS/2 keyboard.
// Prefix codes, matrix geometry, receiver states and key positions.
package jace_ps2_keyboard_pkg;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_DATA,
        RX_PARITY,
        RX_STOP
    } rx_state_e;

    localparam logic [7:0] CODE_REL    = 8'hF0;
    localparam logic [7:0] CODE_EXT    = 8'hE0;
    localparam logic [7:0] CODE_LSHIFT = 8'h12;
    localparam logic [7:0] CODE_RSHIFT = 8'h59;
    localparam logic [7:0] CODE_LCTRL  = 8'h14;

    localparam logic [4:0] NO_KEY = 5'b11111;

    localparam int N_ROWS = 8;
    localparam int N_COLS = 5;

    localparam int ROW_SHIFT = 0;
    localparam int ROW_ASDFG = 1;
    localparam int ROW_QWERT = 2;
    localparam int ROW_12345 = 3;
    localparam int ROW_09876 = 4;
    localparam int ROW_POIUY = 5;
    localparam int ROW_ENTER = 6;
    localparam int ROW_SPACE = 7;

    localparam int COL_0 = 0;
    localparam int COL_1 = 1;
    localparam int COL_2 = 2;
    localparam int COL_3 = 3;
    localparam int COL_4 = 4;

    typedef struct packed {
        logic       hit;
        logic [2:0] row;
        logic [2:0] col;
    } key_pos_t;

    function automatic key_pos_t key_at(input int r, input int c);
        key_pos_t k;
        k.hit = 1'b1;
        k.row = 3'(r);
        k.col = 3'(c);
        return k;
    endfunction

    // Odd parity: data plus parity bit must hold an odd number of ones.
    function automatic logic odd_ok(input logic [7:0] d, input logic p);
        return ^{d, p};
    endfunction

endpackage

// File: rtl/jace_ps2_keyboard_if.sv
// CPU-side view of the keyboard: row select in, columns and
// received-code status out.
interface jace_ps2_keyboard_if;

    logic [7:0] rows;
    logic [4:0] kbdcols;
    logic       code_strobe;
    logic [7:0] code;
    logic       rx_error;

    modport master (
        output rows,
        input  kbdcols,
        input  code_strobe,
        input  code,
        input  rx_error
    );

    modport slave (
        input  rows,
        output kbdcols,
        output code_strobe,
        output code,
        output rx_error
    );

endinterface

// File: rtl/jace_ps2_keymap.sv
// Set-2 scancode to Ace matrix position lookup.
// Extended codes only map E0 14 (right Ctrl) to SymShift.
module jace_ps2_keymap
    import jace_ps2_keyboard_pkg::*;
(
    input  logic [7:0] code,
    input  logic       ext,
    output key_pos_t   pos
);

    always_comb begin
        pos = '0;
        if (ext) begin
            if (code == CODE_LCTRL)
                pos = key_at(ROW_SHIFT, COL_1);
        end else begin
            unique case (code)
                CODE_LSHIFT,
                CODE_RSHIFT: pos = key_at(ROW_SHIFT, COL_0);
                CODE_LCTRL:  pos = key_at(ROW_SHIFT, COL_1);
                8'h1A:       pos = key_at(ROW_SHIFT, COL_2);
                8'h22:       pos = key_at(ROW_SHIFT, COL_3);
                8'h21:       pos = key_at(ROW_SHIFT, COL_4);
                8'h1C:       pos = key_at(ROW_ASDFG, COL_0);
                8'h1B:       pos = key_at(ROW_ASDFG, COL_1);
                8'h23:       pos = key_at(ROW_ASDFG, COL_2);
                8'h2B:       pos = key_at(ROW_ASDFG, COL_3);
                8'h34:       pos = key_at(ROW_ASDFG, COL_4);
                8'h15:       pos = key_at(ROW_QWERT, COL_0);
                8'h1D:       pos = key_at(ROW_QWERT, COL_1);
                8'h24:       pos = key_at(ROW_QWERT, COL_2);
                8'h2D:       pos = key_at(ROW_QWERT, COL_3);
                8'h2C:       pos = key_at(ROW_QWERT, COL_4);
                8'h16:       pos = key_at(ROW_12345, COL_0);
                8'h1E:       pos = key_at(ROW_12345, COL_1);
                8'h26:       pos = key_at(ROW_12345, COL_2);
                8'h25:       pos = key_at(ROW_12345, COL_3);
                8'h2E:       pos = key_at(ROW_12345, COL_4);
                8'h45:       pos = key_at(ROW_09876, COL_0);
                8'h46:       pos = key_at(ROW_09876, COL_1);
                8'h3E:       pos = key_at(ROW_09876, COL_2);
                8'h3D:       pos = key_at(ROW_09876, COL_3);
                8'h36:       pos = key_at(ROW_09876, COL_4);
                8'h4D:       pos = key_at(ROW_POIUY, COL_0);
                8'h44:       pos = key_at(ROW_POIUY, COL_1);
                8'h43:       pos = key_at(ROW_POIUY, COL_2);
                8'h3C:       pos = key_at(ROW_POIUY, COL_3);
                8'h35:       pos = key_at(ROW_POIUY, COL_4);
                8'h5A:       pos = key_at(ROW_ENTER, COL_0);
                8'h4B:       pos = key_at(ROW_ENTER, COL_1);
                8'h42:       pos = key_at(ROW_ENTER, COL_2);
                8'h3B:       pos = key_at(ROW_ENTER, COL_3);
                8'h33:       pos = key_at(ROW_ENTER, COL_4);
                8'h29:       pos = key_at(ROW_SPACE, COL_0);
                8'h3A:       pos = key_at(ROW_SPACE, COL_1);
                8'h31:       pos = key_at(ROW_SPACE, COL_2);
                8'h32:       pos = key_at(ROW_SPACE, COL_3);
                8'h2A:       pos = key_at(ROW_SPACE, COL_4);
                default:     pos = '0;
            endcase
        end
    end

endmodule

// File: rtl/jace_ps2_keyboard.sv
// PS/2 set-2 receiver feeding the Jupiter Ace 8x5 key matrix,
// answering port-FE row selects with active-low columns.
module jace_ps2_keyboard
    import jace_ps2_keyboard_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 6500
) (
    input  logic clk,
    input  logic rst,
    input  logic ps2clk,
    input  logic ps2data,
    jace_ps2_keyboard_if.slave bus
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

    logic [1:0] ck_sync;
    logic [1:0] dt_sync;
    logic [2:0] ck_hist;
    logic       ck_filt;
    logic       fall_q;
    logic       rise_q;
    logic       dat;

    rx_state_e  state_q, state_d;
    logic [2:0] bit_q, bit_d;
    logic [7:0] sh_q, sh_d;
    logic       par_q, par_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic       byte_ok;
    logic       byte_err;

    logic       rel_q;
    logic       ext_q;
    logic [N_ROWS-1:0][N_COLS-1:0] mtx;
    logic [7:0] code_q;
    logic       strobe_q;
    logic       err_q;
    logic [4:0] pressed;
    key_pos_t   kpos;

    // Clock filter: level must hold for three synchronised samples.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ck_sync <= 2'b11;
            dt_sync <= 2'b11;
            ck_hist <= 3'b111;
            ck_filt <= 1'b1;
            fall_q  <= 1'b0;
            rise_q  <= 1'b0;
        end else begin
            ck_sync <= {ck_sync[0], ps2clk};
            dt_sync <= {dt_sync[0], ps2data};
            ck_hist <= {ck_hist[1:0], ck_sync[1]};
            fall_q  <= 1'b0;
            rise_q  <= 1'b0;
            if (ck_filt && ck_hist == 3'b000) begin
                ck_filt <= 1'b0;
                fall_q  <= 1'b1;
            end else if (!ck_filt && ck_hist == 3'b111) begin
                ck_filt <= 1'b1;
                rise_q  <= 1'b1;
            end
        end
    end

    assign dat = dt_sync[1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= RX_IDLE;
            bit_q   <= '0;
            sh_q    <= '0;
            par_q   <= 1'b0;
            tmo_q   <= '0;
        end else begin
            state_q <= state_d;
            bit_q   <= bit_d;
            sh_q    <= sh_d;
            par_q   <= par_d;
            tmo_q   <= tmo_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        bit_d    = bit_q;
        sh_d     = sh_q;
        par_d    = par_q;
        tmo_d    = tmo_q;
        byte_ok  = 1'b0;
        byte_err = 1'b0;
        if (fall_q) begin
            tmo_d = '0;
            unique case (state_q)
                RX_IDLE: begin
                    if (!dat) begin
                        state_d = RX_DATA;
                        bit_d   = '0;
                    end
                end
                RX_DATA: begin
                    sh_d  = {dat, sh_q[7:1]};
                    bit_d = bit_q + 3'd1;
                    if (bit_q == 3'd7)
                        state_d = RX_PARITY;
                end
                RX_PARITY: begin
                    par_d   = dat;
                    state_d = RX_STOP;
                end
                RX_STOP: begin
                    if (dat && odd_ok(sh_q, par_q))
                        byte_ok = 1'b1;
                    else
                        byte_err = 1'b1;
                    state_d = RX_IDLE;
                end
                default: state_d = RX_IDLE;
            endcase
        end else if (rise_q) begin
            tmo_d = '0;
        end else if (state_q != RX_IDLE) begin
            if (tmo_q == TMO_LAST) begin
                state_d = RX_IDLE;
                tmo_d   = '0;
            end else begin
                tmo_d = tmo_q + 1'b1;
            end
        end
    end

    jace_ps2_keymap u_keymap (
        .code (sh_q),
        .ext  (ext_q),
        .pos  (kpos)
    );

    // Prefixes only arm flags; the following byte consumes them.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rel_q    <= 1'b0;
            ext_q    <= 1'b0;
            mtx      <= '0;
            code_q   <= '0;
            strobe_q <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            strobe_q <= byte_ok;
            err_q    <= byte_err;
            if (byte_ok) begin
                code_q <= sh_q;
                if (sh_q == CODE_REL) begin
                    rel_q <= 1'b1;
                end else if (sh_q == CODE_EXT) begin
                    ext_q <= 1'b1;
                end else begin
                    if (kpos.hit)
                        mtx[kpos.row][kpos.col] <= ~rel_q;
                    rel_q <= 1'b0;
                    ext_q <= 1'b0;
                end
            end
        end
    end

    always_comb begin
        pressed = '0;
        for (int r = 0; r < N_ROWS; r++) begin
            if (!bus.rows[r])
                pressed = pressed | mtx[r];
        end
    end

    assign bus.kbdcols     = NO_KEY & ~pressed;
    assign bus.code        = code_q;
    assign bus.code_strobe = strobe_q;
    assign bus.rx_error    = err_q;

endmodule

// File: tb/tb_jace_ps2_keyboard.sv
// Randomised PS/2 frames against a key-table model of the Ace matrix.
module tb_jace_ps2_keyboard;

    localparam int TMO = 300;

    logic clk = 1'b0;
    logic rst;
    logic ps2clk;
    logic ps2data;
    int   cyc = 0;

    jace_ps2_keyboard_if kif();

    jace_ps2_keyboard #(.TIMEOUT_CYCLES(TMO)) dut (
        .clk     (clk),
        .rst     (rst),
        .ps2clk  (ps2clk),
        .ps2data (ps2data),
        .bus     (kif)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int failures = 0;
    bit busy = 1'b0;
    bit rows_hold = 1'b1;
    logic [7:0] rows_fixed = 8'hFF;

    bit held [8][5];
    bit m_rel, m_ext;
    logic [7:0] m_code;
    int nstrobe = 0;
    int nerr = 0;
    int strobe_cyc = 0;
    int fall_cyc = 0;

    logic [7:0] ktab [40] = '{
        8'h12, 8'h14, 8'h1A, 8'h22, 8'h21,
        8'h1C, 8'h1B, 8'h23, 8'h2B, 8'h34,
        8'h15, 8'h1D, 8'h24, 8'h2D, 8'h2C,
        8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E,
        8'h45, 8'h46, 8'h3E, 8'h3D, 8'h36,
        8'h4D, 8'h44, 8'h43, 8'h3C, 8'h35,
        8'h5A, 8'h4B, 8'h42, 8'h3B, 8'h33,
        8'h29, 8'h3A, 8'h31, 8'h32, 8'h2A
    };

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    function automatic logic [4:0] exp_cols(input logic [7:0] r);
        logic [4:0] v = 5'b11111;
        for (int rr = 0; rr < 8; rr++)
            for (int cc = 0; cc < 5; cc++)
                if (held[rr][cc] && !r[rr]) v[cc] = 1'b0;
        return v;
    endfunction

    task automatic model_clear();
        for (int rr = 0; rr < 8; rr++)
            for (int cc = 0; cc < 5; cc++)
                held[rr][cc] = 1'b0;
        m_rel = 1'b0;
        m_ext = 1'b0;
        m_code = 8'h00;
    endtask

    task automatic model_byte(input logic [7:0] d);
        int idx = -1;
        m_code = d;
        if (d == 8'hF0) m_rel = 1'b1;
        else if (d == 8'hE0) m_ext = 1'b1;
        else begin
            if (m_ext) begin
                if (d == 8'h14) idx = 1;
            end else if (d == 8'h59) begin
                idx = 0;
            end else begin
                for (int i = 0; i < 40; i++)
                    if (ktab[i] == d) idx = i;
            end
            if (idx >= 0) held[idx / 5][idx % 5] = !m_rel;
            m_rel = 1'b0;
            m_ext = 1'b0;
        end
    endtask

    always @(posedge clk) begin
        #1;
        kif.rows = rows_hold ? rows_fixed : 8'($urandom);
    end

    always @(negedge clk) begin
        if (!rst) begin
            if (kif.code_strobe) begin
                nstrobe++;
                strobe_cyc = cyc;
            end
            if (kif.rx_error) nerr++;
            if (!busy) begin
                chk("kbdcols", 32'(kif.kbdcols), 32'(exp_cols(kif.rows)));
                chk("code_held", 32'(kif.code), 32'(m_code));
            end
        end
    end

    task automatic wait_clk(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic ps2_bit(input logic b);
        ps2data = b;
        wait_clk(10);
        ps2clk = 1'b0;
        wait_clk(20);
        ps2clk = 1'b1;
        wait_clk(10);
    endtask

    task automatic send_frame(input logic [7:0] d, input bit bad_par = 0,
                              input bit bad_stop = 0);
        int s0 = nstrobe;
        int e0 = nerr;
        bit valid = !bad_par && !bad_stop;
        logic par = ~^d;
        if (bad_par) par = ~par;
        ps2_bit(1'b0);
        for (int i = 0; i < 8; i++) ps2_bit(d[i]);
        ps2_bit(par);
        ps2data = !bad_stop;
        wait_clk(10);
        busy = 1'b1;
        ps2clk = 1'b0;
        fall_cyc = cyc;
        wait_clk(20);
        if (valid) model_byte(d);
        busy = 1'b0;
        ps2clk = 1'b1;
        wait_clk(10);
        ps2data = 1'b1;
        chk("strobes", 32'(nstrobe - s0), 32'(valid));
        chk("errors", 32'(nerr - e0), 32'(!valid));
        if (valid) chk("strobe_lat", 32'(strobe_cyc - fall_cyc), 32'd7);
    endtask

    task automatic pin_cols(input string name, input logic [7:0] r,
                            input logic [4:0] exp);
        rows_hold = 1'b1;
        rows_fixed = r;
        wait_clk(2);
        chk(name, 32'(kif.kbdcols), 32'(exp));
    endtask

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int s0, k;
        logic [7:0] d;
        model_clear();
        rst = 1'b1;
        ps2clk = 1'b1;
        ps2data = 1'b1;
        rows_fixed = 8'h00;
        wait_clk(3);
        chk("rst_cols", 32'(kif.kbdcols), 32'h1F);
        chk("rst_code", 32'(kif.code), 32'h00);
        chk("rst_strobe", 32'(kif.code_strobe), 32'h0);
        chk("rst_err", 32'(kif.rx_error), 32'h0);
        rst = 1'b0;
        wait_clk(10);

        send_frame(8'h1C);
        chk("code_1C", 32'(kif.code), 32'h1C);
        pin_cols("a_fd", 8'hFD, 5'b11110);
        pin_cols("a_ff", 8'hFF, 5'b11111);

        s0 = nstrobe;
        send_frame(8'hF0);
        pin_cols("f0_nochg", 8'hFD, 5'b11110);
        send_frame(8'h1C);
        chk("two_strobes", 32'(nstrobe - s0), 32'd2);
        pin_cols("a_rel", 8'hFD, 5'b11111);

        send_frame(8'h12);
        send_frame(8'h29);
        pin_cols("shift_space", 8'h7E, 5'b11110);
        send_frame(8'hF0);
        send_frame(8'h59);
        pin_cols("shift_gone", 8'hFE, 5'b11111);
        pin_cols("space_held", 8'h7F, 5'b11110);

        send_frame(8'h1C, 1, 0);
        send_frame(8'h1C, 0, 1);
        pin_cols("err_nochg", 8'hFD, 5'b11111);

        s0 = nstrobe;
        k = nerr;
        ps2_bit(1'b0);
        for (int i = 0; i < 4; i++) ps2_bit(1'($urandom));
        wait_clk(TMO + 60);
        chk("tmo_nostrobe", 32'(nstrobe - s0), 32'd0);
        chk("tmo_noerr", 32'(nerr - k), 32'd0);
        send_frame(8'h1B);
        chk("code_1B", 32'(kif.code), 32'h1B);
        pin_cols("s_set", 8'hFD, 5'b11101);

        rows_hold = 1'b0;
        for (int n = 0; n < 40; n++) begin
            k = $urandom_range(0, 9);
            d = (k < 7) ? ktab[$urandom_range(0, 39)] : 8'($urandom);
            if ($urandom_range(0, 40) == 0) d = 8'h59;
            if (k < 5) begin
                send_frame(d);
            end else if (k < 7) begin
                send_frame(8'hF0);
                send_frame(d);
            end else if (k == 7) begin
                send_frame(8'hE0);
                if ($urandom_range(0, 1) == 1) send_frame(8'hF0);
                send_frame($urandom_range(0, 1) == 1 ? 8'h14 : d);
            end else if (k == 8) begin
                send_frame(d);
            end else begin
                if ($urandom_range(0, 1) == 1) send_frame(d, 1, 0);
                else send_frame(d, $urandom_range(0, 1) == 1, 1);
            end
        end

        send_frame(8'h1C);
        rows_hold = 1'b1;
        rows_fixed = 8'h00;
        wait_clk(2);
        ps2_bit(1'b0);
        for (int i = 0; i < 3; i++) ps2_bit(1'b1);
        ps2data = 1'b0;
        ps2clk = 1'b0;
        #2;
        rst = 1'b1;
        model_clear();
        #1;
        chk("midrst_cols", 32'(kif.kbdcols), 32'h1F);
        chk("midrst_code", 32'(kif.code), 32'h00);
        ps2clk = 1'b1;
        ps2data = 1'b1;
        wait_clk(5);
        rst = 1'b0;
        wait_clk(20);
        send_frame(8'h1C);
        chk("post_rst_code", 32'(kif.code), 32'h1C);
        pin_cols("post_rst_a", 8'hFD, 5'b11110);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
